dac_spi_tx: RTL and testbench
=============================

Name: dac_spi_tx

Overview:
- Downstream stage of the 16-bit DAC output selector.
- Takes one 16-bit offset-binary sample per handshake, packs it into a 32-bit DAC command frame and shifts it out MSB-first on a 3-wire SPI link (SCK, MOSI, CS_n) to the external DAC.
- Provides valid/ready back-pressure so the QAM sample path stalls while a frame is on the wire.

Parameters:
- CLK_DIV, 4: SCK half-period in clk cycles; legal range 1..255.
- CMD, 4'b0011: DAC command nibble ("write and update").
- ADDR, 4'b1111: DAC channel address nibble (all channels).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  16  sample from the DAC output selector, offset binary.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  block can accept a sample (high only in IDLE).
- spi_sck  out  1  serial clock; idles low; DAC samples MOSI on the rising edge.
- spi_mosi  out  1  serial data, MSB first.
- dac_cs_n  out  1  chip select, active low; the DAC updates on its rising edge.
- busy  out  1  high from the accept cycle until return to IDLE.
- frame_done  out  1  one-cycle pulse on the cycle dac_cs_n rises.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state=IDLE; dac_cs_n=1; spi_sck=0; spi_mosi=0; busy=0; frame_done=0; counters=0.
  - din_ready=1 once reset is released.
- Frame format, bit 31 sent first:
  - [31:24]=8'h00
  - [23:20]=CMD
  - [19:16]=ADDR
  - [15:4]=din[15:4] (top 12 bits; din[3:0] dropped, no rounding)
  - [3:0]=4'h0
- Accept: din_valid && din_ready on a clk edge latches the frame into the shift register. din and din_valid are ignored in every other state.
- States: IDLE -> SHIFT -> TAIL -> GAP -> IDLE.
  - IDLE: din_ready=1, dac_cs_n=1, spi_sck=0. On accept -> SHIFT; next cycle dac_cs_n=0, spi_mosi=bit31, busy=1.
  - SHIFT: 32 bits. Each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles. spi_mosi changes only at the start of a low phase, so it is stable for CLK_DIV cycles before each rising SCK edge. After the high phase of bit 0 (last bit) -> TAIL.
  - TAIL: spi_sck=0, dac_cs_n=0 for CLK_DIV cycles. Then dac_cs_n=1, frame_done=1 for one cycle, spi_mosi=0 -> GAP.
  - GAP: dac_cs_n=1 for CLK_DIV cycles (minimum CS-high time) -> IDLE.
- Timing, derived from the state sequence:
  - dac_cs_n low for exactly 65*CLK_DIV cycles.
  - Exactly 32 rising SCK edges per frame.
  - din_ready reasserts 66*CLK_DIV+1 cycles after the accept edge; with CLK_DIV=4 that is 265.
  - Back-to-back throughput is one sample per 66*CLK_DIV+1 cycles.
- din_valid held high continuously: a new sample is accepted on the first IDLE cycle, with no idle gap beyond the above.
- Counters:
  - Bit counter: 6 bits, counts 0..31; it does not wrap into a 33rd SCK edge.
  - Phase counter: 8 bits, reloads every CLK_DIV cycles.
- All outputs are registered; no combinational path from din to the SPI pins.

Test Plan:
- Reset release: hold rst_n=0 for 5 cycles, then release -> dac_cs_n=1, spi_sck=0, spi_mosi=0, busy=0, frame_done=0, din_ready=1.
- Single frame, CLK_DIV=4, din=16'd1000 (16'h03E8):
  - Bits captured on SCK rising edges = 32'h003F03E0.
  - 32 rising edges; dac_cs_n low for 260 cycles.
  - frame_done pulses once; din_ready high again 265 cycles after accept.
- Full scale, din=16'hFFFF, then din=16'h0000 back-to-back with din_valid held high:
  - Frames are 32'h003FFFF0 then 32'h003F0000.
  - Second accept occurs exactly 265 cycles after the first.
  - A value on din changed mid-frame never appears on MOSI.
- Stall handling: pulse din_valid with din=16'h1234 while busy -> ignored, and no second frame follows the current one.
- Reset mid-frame: assert rst_n=0 at SCK edge 10 of a frame:
  - Same cycle: dac_cs_n=1, spi_sck=0.
  - No frame_done pulse.
  - After release, a new frame with din=16'h8000 -> 32'h003F8000 sent cleanly.
- CLK_DIV=1 build, din=16'h03E8 -> SCK period 2 cycles, 32'h003F03E0, dac_cs_n low 65 cycles, din_ready back after 67 cycles.

Source files
------------

// File: rtl/dac_spi_tx.sv
// Serialises one 16-bit offset-binary sample per handshake into a 32-bit DAC command
// frame on a 3-wire SPI link (SCK idles low, MOSI MSB first, CS_n active low).
module dac_spi_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [3:0]  CMD     = 4'b0011,
    parameter logic [3:0]  ADDR    = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        dac_cs_n,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_TAIL  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST   = 6'd31;

    logic [1:0]  state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [5:0]  bit_q, bit_d;
    logic [31:0] shreg_q, shreg_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;

    logic [31:0] frame_s;
    logic        phase_end_s;
    logic        din_unused_s;

    // The DAC takes 12 bits; the low nibble of the sample is truncated.
    assign frame_s      = {8'h00, CMD, ADDR, din[15:4], 4'h0};
    assign din_unused_s = ^din[3:0];
    assign phase_end_s  = (phase_q == PHASE_LAST);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (din_valid && ready_q) begin
                    shreg_d = frame_s;
                    mosi_d  = frame_s[31];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    sck_d   = 1'b0;
                    phase_d = 8'd0;
                    bit_d   = 6'd0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (phase_end_s) begin
                    phase_d = 8'd0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        // MOSI only moves here, at the start of a low phase.
                        if (bit_q == BIT_LAST) begin
                            state_d = S_TAIL;
                        end else begin
                            bit_d   = bit_q + 6'd1;
                            shreg_d = {shreg_q[30:0], 1'b0};
                            mosi_d  = shreg_q[30];
                        end
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_TAIL: begin
                if (phase_end_s) begin
                    phase_d = 8'd0;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = S_GAP;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_GAP: begin
                if (phase_end_s) begin
                    phase_d = 8'd0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 8'd0;
                bit_d   = 6'd0;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset forces the link idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= 8'd0;
            bit_q   <= 6'd0;
            shreg_q <= 32'd0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign din_ready  = ready_q;
    assign spi_sck    = sck_q;
    assign spi_mosi   = mosi_q;
    assign dac_cs_n   = cs_n_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a CLK_DIV=4 and a CLK_DIV=1 instance, an SPI-pin monitor and a
// frame-level reference model that predicts accepts, frames and din_ready timing.
module tb_dac_spi_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] din_s       [2];
    logic        din_valid_s [2];
    logic        din_ready_s [2];
    logic        sck_s       [2];
    logic        mosi_s      [2];
    logic        cs_n_s      [2];
    logic        busy_s      [2];
    logic        done_s      [2];

    int n_vec = 0;
    int n_err = 0;

    dac_spi_tx #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din_s[0]), .din_valid(din_valid_s[0]),
        .din_ready(din_ready_s[0]), .spi_sck(sck_s[0]), .spi_mosi(mosi_s[0]),
        .dac_cs_n(cs_n_s[0]), .busy(busy_s[0]), .frame_done(done_s[0])
    );

    dac_spi_tx #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din_s[1]), .din_valid(din_valid_s[1]),
        .din_ready(din_ready_s[1]), .spi_sck(sck_s[1]), .spi_mosi(mosi_s[1]),
        .dac_cs_n(cs_n_s[1]), .busy(busy_s[1]), .frame_done(done_s[1])
    );

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Reference: the 12 kept bits sit under the fixed 0x003F command/address prefix.
    function automatic logic [31:0] model_frame(input logic [15:0] d);
        return 32'h003F_0000 + 32'(d & 16'hFFF0);
    endfunction

    int          cyc = 0;
    int          free_at   [2];
    logic [31:0] exp_frame [2][16];
    int          exp_acc   [2][16];
    int          n_exp     [2];
    int          dut_acc   [2][16];
    int          n_dacc    [2];
    logic [31:0] got_frame [2][16];
    int          got_rises [2][16];
    int          got_low   [2][16];
    int          got_setup [2][16];
    logic        got_done  [2][16];
    int          n_got     [2];
    int          n_done    [2];
    int          n_stray   [2];
    int          n_rdy_bad [2];
    logic        in_frame  [2];
    logic        prev_sck  [2];
    logic        prev_mosi [2];
    logic [31:0] bits      [2];
    int          rises     [2];
    int          low_cnt   [2];
    int          stable    [2];
    int          min_setup [2];

    // Model and pin monitor, sampled on the falling edge; cyc labels the coming rising edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    free_at[k] = cyc + 1;
                    n_exp[k] = 0; n_dacc[k] = 0; n_rdy_bad[k] = 0;
                    n_got[k] = 0; n_done[k] = 0; n_stray[k] = 0;
                    in_frame[k] = 1'b0; prev_sck[k] = 1'b0; prev_mosi[k] = 1'b0;
                    rises[k] = 0; low_cnt[k] = 0; bits[k] = 32'd0;
                end else begin
                    if (din_ready_s[k] !== (cyc >= free_at[k])) n_rdy_bad[k]++;
                    if (din_valid_s[k] && din_ready_s[k] && n_dacc[k] < 16) begin
                        dut_acc[k][n_dacc[k]] = cyc;
                        n_dacc[k]++;
                    end
                    if (din_valid_s[k] && cyc >= free_at[k] && n_exp[k] < 16) begin
                        exp_frame[k][n_exp[k]] = model_frame(din_s[k]);
                        exp_acc[k][n_exp[k]] = cyc;
                        n_exp[k]++;
                        free_at[k] = cyc + 66 * div_of(k) + 1;
                    end
                    if (done_s[k]) n_done[k]++;
                    if (cs_n_s[k] && (sck_s[k] || mosi_s[k])) n_stray[k]++;
                    if (!cs_n_s[k]) begin
                        if (!in_frame[k] || mosi_s[k] != prev_mosi[k]) stable[k] = 1;
                        else stable[k]++;
                        if (!in_frame[k]) begin
                            in_frame[k] = 1'b1; bits[k] = 32'd0; rises[k] = 0;
                            low_cnt[k] = 0; min_setup[k] = 1000;
                        end
                        low_cnt[k]++;
                        if (sck_s[k] && !prev_sck[k]) begin
                            bits[k] = {bits[k][30:0], mosi_s[k]};
                            rises[k]++;
                            if (stable[k] < min_setup[k]) min_setup[k] = stable[k];
                        end
                    end else if (in_frame[k]) begin
                        in_frame[k] = 1'b0;
                        if (n_got[k] < 16) begin
                            got_frame[k][n_got[k]] = bits[k];
                            got_rises[k][n_got[k]] = rises[k];
                            got_low[k][n_got[k]]   = low_cnt[k];
                            got_setup[k][n_got[k]] = min_setup[k];
                            got_done[k][n_got[k]]  = done_s[k];
                            n_got[k]++;
                        end
                    end
                    prev_sck[k]  = sck_s[k];
                    prev_mosi[k] = mosi_s[k];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_got(input int k, input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (n_got[k] < n && c < budget) begin
            tick();
            c++;
        end
        ok = (n_got[k] >= n);
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            n_vec += 6;
            if (cs_n_s[k] !== 1'b1) begin n_err++; $display("FAIL reset_cs_n[%0d]: got %b want 1", k, cs_n_s[k]); end
            if (sck_s[k] !== 1'b0) begin n_err++; $display("FAIL reset_sck[%0d]: got %b want 0", k, sck_s[k]); end
            if (mosi_s[k] !== 1'b0) begin n_err++; $display("FAIL reset_mosi[%0d]: got %b want 0", k, mosi_s[k]); end
            if (busy_s[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy_s[k]); end
            if (done_s[k] !== 1'b0) begin n_err++; $display("FAIL reset_done[%0d]: got %b want 0", k, done_s[k]); end
            if (din_ready_s[k] !== 1'b1) begin n_err++; $display("FAIL reset_ready[%0d]: got %b want 1", k, din_ready_s[k]); end
        end
    endtask

    task automatic test_single_frame(input int k, input logic [15:0] d, input logic [31:0] want,
                                     input int want_low, input int want_ready_edge);
        int c;
        apply_reset();
        din_s[k] = d;
        din_valid_s[k] = 1'b1;
        tick();
        din_valid_s[k] = 1'b0;
        din_s[k] = 16'($urandom);
        c = 0;
        while (din_ready_s[k] !== 1'b1 && c < 2000) begin
            tick();
            c++;
        end
        // c counts edges until din_ready is visible; the next edge is the earliest accept.
        n_vec += 10;
        if (c + 1 !== want_ready_edge) begin n_err++; $display("FAIL single_ready_edge[%0d]: got %0d want %0d", k, c + 1, want_ready_edge); end
        if (n_got[k] !== 1) begin n_err++; $display("FAIL single_nframes[%0d]: got %0d want 1", k, n_got[k]); end
        if (got_frame[k][0] !== want) begin n_err++; $display("FAIL single_frame[%0d]: got %h want %h", k, got_frame[k][0], want); end
        if (got_frame[k][0] !== exp_frame[k][0]) begin n_err++; $display("FAIL single_model[%0d]: got %h want %h", k, got_frame[k][0], exp_frame[k][0]); end
        if (got_rises[k][0] !== 32) begin n_err++; $display("FAIL single_rises[%0d]: got %0d want 32", k, got_rises[k][0]); end
        if (got_low[k][0] !== want_low) begin n_err++; $display("FAIL single_cs_low[%0d]: got %0d want %0d", k, got_low[k][0], want_low); end
        if (got_setup[k][0] !== div_of(k) + 1) begin n_err++; $display("FAIL single_setup[%0d]: got %0d want %0d", k, got_setup[k][0], div_of(k) + 1); end
        if (got_done[k][0] !== 1'b1 || n_done[k] !== 1) begin n_err++; $display("FAIL single_done[%0d]: got %b/%0d want 1/1", k, got_done[k][0], n_done[k]); end
        if (n_rdy_bad[k] !== 0) begin n_err++; $display("FAIL single_ready_track[%0d]: got %0d want 0", k, n_rdy_bad[k]); end
        if (n_stray[k] !== 0) begin n_err++; $display("FAIL single_idle_pins[%0d]: got %0d want 0", k, n_stray[k]); end
    endtask

    task automatic test_back_to_back();
        int c;
        bit ok;
        apply_reset();
        din_s[0] = 16'hFFFF;
        din_valid_s[0] = 1'b1;
        tick();
        c = 1;
        while (n_dacc[0] < 2 && c < 400) begin
            din_s[0] = (c < 260) ? 16'($urandom) : 16'h0000;
            tick();
            c++;
        end
        din_valid_s[0] = 1'b0;
        wait_got(0, 2, 600, ok);
        n_vec += 7;
        if (!ok || n_got[0] !== 2) begin n_err++; $display("FAIL b2b_nframes: got %0d want 2", n_got[0]); end
        if (n_dacc[0] !== 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", n_dacc[0]); end
        if (got_frame[0][0] !== 32'h003FFFF0) begin n_err++; $display("FAIL b2b_frame0: got %h want 003ffff0", got_frame[0][0]); end
        if (got_frame[0][1] !== 32'h003F0000) begin n_err++; $display("FAIL b2b_frame1: got %h want 003f0000", got_frame[0][1]); end
        if (dut_acc[0][1] - dut_acc[0][0] !== 265) begin n_err++; $display("FAIL b2b_spacing: got %0d want 265", dut_acc[0][1] - dut_acc[0][0]); end
        if (n_done[0] !== 2) begin n_err++; $display("FAIL b2b_done: got %0d want 2", n_done[0]); end
        if (n_rdy_bad[0] !== 0) begin n_err++; $display("FAIL b2b_ready_track: got %0d want 0", n_rdy_bad[0]); end
    endtask

    task automatic test_stall();
        logic [15:0] d0;
        apply_reset();
        d0 = 16'($urandom);
        din_s[0] = d0;
        din_valid_s[0] = 1'b1;
        tick();
        din_valid_s[0] = 1'b0;
        repeat (40) tick();
        din_s[0] = 16'h1234;
        din_valid_s[0] = 1'b1;
        tick();
        din_valid_s[0] = 1'b0;
        repeat (219) tick();
        din_valid_s[0] = 1'b1;
        tick();
        din_valid_s[0] = 1'b0;
        repeat (300) tick();
        n_vec += 5;
        if (n_dacc[0] !== 1) begin n_err++; $display("FAIL stall_accepts: got %0d want 1", n_dacc[0]); end
        if (n_got[0] !== 1) begin n_err++; $display("FAIL stall_nframes: got %0d want 1", n_got[0]); end
        if (got_frame[0][0] !== model_frame(d0)) begin n_err++; $display("FAIL stall_frame: got %h want %h", got_frame[0][0], model_frame(d0)); end
        if (n_done[0] !== 1) begin n_err++; $display("FAIL stall_done: got %0d want 1", n_done[0]); end
        if (n_rdy_bad[0] !== 0) begin n_err++; $display("FAIL stall_ready_track: got %0d want 0", n_rdy_bad[0]); end
    endtask

    task automatic test_reset_mid_frame();
        int c;
        bit ok;
        apply_reset();
        din_s[0] = 16'($urandom);
        din_valid_s[0] = 1'b1;
        tick();
        din_valid_s[0] = 1'b0;
        c = 0;
        while (rises[0] < 10 && c < 200) begin
            tick();
            c++;
        end
        n_vec += 2;
        if (rises[0] < 10) begin n_err++; $display("FAIL midrst_reach_edge10: got %0d want 10", rises[0]); end
        if (n_done[0] !== 0) begin n_err++; $display("FAIL midrst_early_done: got %0d want 0", n_done[0]); end
        rst_n = 1'b0;
        #1;
        n_vec += 4;
        if (cs_n_s[0] !== 1'b1) begin n_err++; $display("FAIL midrst_cs_n: got %b want 1", cs_n_s[0]); end
        if (sck_s[0] !== 1'b0) begin n_err++; $display("FAIL midrst_sck: got %b want 0", sck_s[0]); end
        if (done_s[0] !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done_s[0]); end
        if (busy_s[0] !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy_s[0]); end
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        din_s[0] = 16'h8000;
        din_valid_s[0] = 1'b1;
        tick();
        din_valid_s[0] = 1'b0;
        wait_got(0, 1, 400, ok);
        repeat (8) tick();
        n_vec += 4;
        if (!ok || n_got[0] !== 1) begin n_err++; $display("FAIL midrst_nframes: got %0d want 1", n_got[0]); end
        if (got_frame[0][0] !== 32'h003F8000) begin n_err++; $display("FAIL midrst_frame: got %h want 003f8000", got_frame[0][0]); end
        if (got_rises[0][0] !== 32) begin n_err++; $display("FAIL midrst_rises: got %0d want 32", got_rises[0][0]); end
        if (n_done[0] !== 1) begin n_err++; $display("FAIL midrst_done_count: got %0d want 1", n_done[0]); end
    endtask

    task automatic test_random(input int k, input int n);
        int c;
        int tgt;
        bit ok;
        apply_reset();
        for (int i = 0; i < n; i++) begin
            din_s[k] = 16'($urandom);
            din_valid_s[k] = 1'b1;
            tgt = n_dacc[k] + 1;
            c = 0;
            while (n_dacc[k] < tgt && c < 1000) begin
                tick();
                c++;
            end
            n_vec++;
            if (n_dacc[k] < tgt) begin n_err++; $display("FAIL rand_accept_timeout[%0d]: got %0d want %0d", k, n_dacc[k], tgt); end
            repeat ($urandom_range(0, 40)) begin
                din_s[k] = 16'($urandom);
                din_valid_s[k] = 1'($urandom_range(0, 1));
                tick();
            end
            din_valid_s[k] = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        din_valid_s[k] = 1'b0;
        tick();
        wait_got(k, n_exp[k], 600, ok);
        repeat (div_of(k) + 3) tick();
        n_vec += 5;
        if (!ok || n_got[k] !== n_exp[k]) begin n_err++; $display("FAIL rand_nframes[%0d]: got %0d want %0d", k, n_got[k], n_exp[k]); end
        if (n_dacc[k] !== n_exp[k]) begin n_err++; $display("FAIL rand_accepts[%0d]: got %0d want %0d", k, n_dacc[k], n_exp[k]); end
        if (n_done[k] !== n_exp[k]) begin n_err++; $display("FAIL rand_done[%0d]: got %0d want %0d", k, n_done[k], n_exp[k]); end
        if (n_rdy_bad[k] !== 0) begin n_err++; $display("FAIL rand_ready_track[%0d]: got %0d want 0", k, n_rdy_bad[k]); end
        if (n_stray[k] !== 0) begin n_err++; $display("FAIL rand_idle_pins[%0d]: got %0d want 0", k, n_stray[k]); end
        for (int i = 0; i < n_got[k]; i++) begin
            n_vec += 5;
            if (got_frame[k][i] !== exp_frame[k][i]) begin n_err++; $display("FAIL rand_frame[%0d][%0d]: got %h want %h", k, i, got_frame[k][i], exp_frame[k][i]); end
            if (dut_acc[k][i] !== exp_acc[k][i]) begin n_err++; $display("FAIL rand_accept_time[%0d][%0d]: got %0d want %0d", k, i, dut_acc[k][i], exp_acc[k][i]); end
            if (got_rises[k][i] !== 32) begin n_err++; $display("FAIL rand_rises[%0d][%0d]: got %0d want 32", k, i, got_rises[k][i]); end
            if (got_low[k][i] !== 65 * div_of(k)) begin n_err++; $display("FAIL rand_cs_low[%0d][%0d]: got %0d want %0d", k, i, got_low[k][i], 65 * div_of(k)); end
            if (got_setup[k][i] !== div_of(k) + 1) begin n_err++; $display("FAIL rand_setup[%0d][%0d]: got %0d want %0d", k, i, got_setup[k][i], div_of(k) + 1); end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            din_s[k] = 16'h0000;
            din_valid_s[k] = 1'b0;
        end
        test_reset();
        test_single_frame(0, 16'h03E8, 32'h003F03E0, 260, 265);
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        test_single_frame(1, 16'h03E8, 32'h003F03E0, 65, 67);
        test_random(0, 5);
        test_random(1, 12);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
